uart_tx_buffered: RTL and testbench

Transmit end of the memory-mapped UART path. Accepts bytes written by the data-memory stage when it asserts uart_we (store to UART_TX_ADDR). Buffers them in a small FIFO and serialises each as an 8N1 frame, LSB first, on uart_tx. Sits beside the data memory; uart_tx goes to the board pin.

---
 rtl/uart_tx_buffered_pkg.sv | 27 ++
 rtl/uart_tx_fifo.sv | 73 +++++++
 rtl/uart_tx_buffered.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// ============================================================================
// Module   : uart_tx_buffered_pkg
// Brief    : Shared types and constants for the buffered UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_buffered_pkg;

    localparam int UART_CLKS_PER_BIT_DEFAULT = 868;   // 100 MHz / 115200 baud
    localparam int UART_FIFO_DEPTH_DEFAULT   = 16;

    typedef enum logic [2:0] {
        UART_ST_IDLE   = 3'd0,
        UART_ST_START  = 3'd1,
        UART_ST_DATA   = 3'd2,
        UART_ST_PARITY = 3'd3,
        UART_ST_STOP   = 3'd4
    } uart_state_e;

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Synchronous byte FIFO; full is judged on the registered count,
//            so a push in a full cycle is dropped even if a pop also occurs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int              PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == FULL_COUNT);
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_buffered.sv
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : Memory-mapped UART transmitter: byte FIFO feeding an 8N1 (or 8E1
//            with UART_TX_PARITY_EN defined) serialiser, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_we,
    input  logic [31:0] wdata,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    uart_state_e       state_q;
    uart_state_e       state_d;
    logic [BAUD_W-1:0] baud_q;
    logic [BAUD_W-1:0] baud_d;
    logic [2:0]        bit_q;
    logic [2:0]        bit_d;
    logic [7:0]        shift_q;
    logic [7:0]        shift_d;
    logic              uart_tx_q;
    logic              uart_tx_d;
    logic              tx_busy_q;
    logic              overflow_q;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
    logic              parity_d;
`endif

    logic              baud_done;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full_w;
    logic [7:0]        fifo_dout;
    logic              unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[31:8];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (uart_we),
        .din   (wdata[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full_w)
    );

    assign baud_done = (baud_q == BAUD_LAST);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UART_ST_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            tx_busy_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            uart_tx_q  <= uart_tx_d;
            tx_busy_q  <= (state_q != UART_ST_IDLE) || !fifo_empty;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
            if (uart_we && fifo_full_w) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        // The baud counter free-runs inside a bit and reloads at every boundary.
        if (state_q == UART_ST_IDLE || baud_done) begin
            baud_d = '0;
        end else begin
            baud_d = baud_q + 1'b1;
        end

        case (state_q)
            UART_ST_IDLE: begin
                bit_d = '0;
                if (!fifo_empty) begin
                    shift_d = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = even_parity(fifo_dout);
`endif
                    state_d = UART_ST_START;
                end
            end
            UART_ST_START: begin
                if (baud_done) begin
                    state_d = UART_ST_DATA;
                end
            end
            UART_ST_DATA: begin
                if (baud_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = UART_ST_PARITY;
`else
                        state_d = UART_ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_ST_PARITY: begin
                if (baud_done) begin
                    state_d = UART_ST_STOP;
                end
            end
`endif
            UART_ST_STOP: begin
                if (baud_done) begin
                    state_d = UART_ST_IDLE;
                end
            end
            default: begin
                state_d = UART_ST_IDLE;
            end
        endcase
    end

    // Output logic; the line value is registered so uart_tx lags state by a cycle.
    always_comb begin
        uart_tx_d = 1'b1;
        fifo_pop  = 1'b0;
        case (state_q)
            UART_ST_IDLE:   fifo_pop  = !fifo_empty;
            UART_ST_START:  uart_tx_d = 1'b0;
            UART_ST_DATA:   uart_tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            UART_ST_PARITY: uart_tx_d = parity_q;
`endif
            UART_ST_STOP:   uart_tx_d = 1'b1;
            default:        uart_tx_d = 1'b1;
        endcase
    end

    assign uart_tx   = uart_tx_q;
    assign tx_busy   = tx_busy_q;
    assign fifo_full = fifo_full_w;
    assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Directed bench for uart_tx_buffered (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_buffered;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        uart_we;
    logic [31:0] wdata;
    logic        uart_tx;
    logic        tx_busy;
    logic        fifo_full;
    logic        overflow;

    int total;
    int bad;

    uart_tx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .uart_we   (uart_we),
        .wdata     (wdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one write strobe, captured at the next rising edge.
    task automatic push(input logic [31:0] w);
        uart_we = 1'b1;
        wdata   = w;
        @(posedge clk);
        #1;
        uart_we = 1'b0;
        wdata   = 32'h0;
    endtask

    // Leaves the caller at the negedge of the first start-bit cycle.
    task automatic wait_start();
        int n;
        n = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("start_timeout", 32'(n < 64), 32'd1);
    endtask

    // Samples the last cycle of every bit; 'at' is the current start-bit cycle index.
    task automatic check_frame(input logic [7:0] b, input int at);
        repeat (CPB - 1 - at) @(negedge clk);
        chk("start_bit", 32'(uart_tx), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            chk($sformatf("data_%02h_bit%0d", b, i), 32'(uart_tx), 32'(b[i]));
        end
`ifdef UART_TX_PARITY_EN
        repeat (CPB) @(negedge clk);
        chk("parity_bit", 32'(uart_tx), 32'(^b));
`endif
        repeat (CPB) @(negedge clk);
        chk("stop_bit", 32'(uart_tx), 32'd1);
    endtask

    // Exactly one idle cycle, then the next start bit.
    task automatic gap();
        @(negedge clk);
        chk("idle_gap", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("next_start", 32'(uart_tx), 32'd0);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        uart_we = 1'b0;
        wdata   = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", 32'(uart_tx), 32'd1);
        chk("rst_busy", 32'(tx_busy), 32'd0);
        chk("rst_full", 32'(fifo_full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("idle_tx", 32'(uart_tx), 32'd1);
        chk("idle_busy", 32'(tx_busy), 32'd0);

        // Single byte 0xA5: start bit two edges after the write edge
        push(32'h0000_00A5);
        @(negedge clk);
        chk("lat_p0", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("lat_p1", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("lat_p2", 32'(uart_tx), 32'd0);
        chk("busy_start", 32'(tx_busy), 32'd1);
        check_frame(8'hA5, 0);
        chk("busy_stop", 32'(tx_busy), 32'd1);
        repeat (4) @(negedge clk);
        chk("busy_done", 32'(tx_busy), 32'd0);
        chk("tx_done", 32'(uart_tx), 32'd1);

        // Six back-to-back writes into a 4-deep FIFO: five kept, sixth dropped
        for (int k = 1; k <= 6; k++) begin
            push(32'(k));
        end
        @(negedge clk);
        chk("burst_ovf", 32'(overflow), 32'd1);
        chk("burst_full", 32'(fifo_full), 32'd1);
        check_frame(8'h01, 3);
        for (int k = 2; k <= 5; k++) begin
            gap();
            check_frame(8'(k), 0);
        end
        repeat (4) @(negedge clk);
        chk("burst_busy_done", 32'(tx_busy), 32'd0);
        chk("burst_ovf_sticky", 32'(overflow), 32'd1);
        chk("burst_tx_idle", 32'(uart_tx), 32'd1);

        // Reset during data bit 3; queued 0xAA must be discarded
        push(32'h0000_0000);
        push(32'h0000_00AA);
        wait_start();
        repeat (4 * CPB + 1) @(negedge clk);
        chk("pre_rst_bit3", 32'(uart_tx), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_tx", 32'(uart_tx), 32'd1);
        chk("midrst_busy", 32'(tx_busy), 32'd0);
        chk("midrst_full", 32'(fifo_full), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        push(32'h0000_003C);
        wait_start();
        check_frame(8'h3C, 0);
        repeat (6) @(negedge clk);
        chk("postrst_busy", 32'(tx_busy), 32'd0);
        chk("postrst_tx", 32'(uart_tx), 32'd1);

        // Full FIFO plus a write in the very cycle IDLE pops: write dropped
        push(32'h0000_0011);
        push(32'h0000_0022);
        push(32'h0000_0033);
        push(32'h0000_0044);
        push(32'h0000_0055);
        @(negedge clk);
        chk("fill_full", 32'(fifo_full), 32'd1);
        repeat (37) @(negedge clk);
        chk("fill_stop", 32'(uart_tx), 32'd1);
        chk("fill_full_at_pop", 32'(fifo_full), 32'd1);
        chk("fill_ovf_before", 32'(overflow), 32'd0);
        push(32'h0000_0099);
        @(negedge clk);
        chk("pop_push_ovf", 32'(overflow), 32'd1);
        chk("pop_push_count3", 32'(fifo_full), 32'd0);
        chk("pop_push_idle", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("pop_push_start", 32'(uart_tx), 32'd0);
        check_frame(8'h22, 0);
        gap();
        check_frame(8'h33, 0);
        gap();
        check_frame(8'h44, 0);
        gap();
        check_frame(8'h55, 0);
        repeat (6) @(negedge clk);
        chk("dropped_not_sent", 32'(tx_busy), 32'd0);

        // Upper store-data bits are ignored
        push(32'hDEAD_BE41);
        wait_start();
        check_frame(8'h41, 0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; 44-cycle frames plus one idle
        repeat (4) @(negedge clk);
        push(32'h0000_0007);
        push(32'h0000_0003);
        wait_start();
        check_frame(8'h07, 0);
        gap();
        check_frame(8'h03, 0);
`endif

        repeat (6) @(negedge clk);
        chk("final_busy", 32'(tx_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
